// File: rtl/mem_game_pkg.sv
// Shared types and constants for the 4x4 memory-card game sequencer.
package mem_game_pkg;

  localparam int unsigned N_CARDS = 16;
  localparam int unsigned GRID    = 4;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned ID_W    = 3;

  localparam logic [47:0] DEFAULT_LAYOUT = 48'hFAC688_FAC688;

  typedef enum logic [2:0] {
    PICK1,
    PICK2,
    SHOW,
    EVAL,
    WON
  } state_e;

  // Pair id of card idx: 3-bit field idx of the layout word.
  function automatic logic [ID_W-1:0] pair_id(input logic [47:0] layout,
                                              input logic [IDX_W-1:0] idx);
    logic [5:0] base;
    base = 6'(idx) * 6'd3;
    return layout[base +: 3];
  endfunction

endpackage

// File: rtl/memory_game_ctrl_btn_edge.sv
// Registered rising-edge pulse from a debounced button level.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic pulse_o
);

  logic prev_q;
  logic pulse_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      prev_q  <= btn_i;
      pulse_q <= btn_i & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/memory_game_ctrl.sv
// Memory-card game sequencer: cursor, two-pick selection, timed reveal,
// then match-keep or flip-back of the picked pair.
module memory_game_ctrl
  import mem_game_pkg::*;
#(
  parameter int unsigned SHOW_CYCLES = 25_000_000,
  parameter logic [47:0] LAYOUT      = DEFAULT_LAYOUT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 btn_up,
  input  logic                 btn_down,
  input  logic                 btn_left,
  input  logic                 btn_right,
  input  logic                 btn_sel,
  output logic [IDX_W-1:0]     cursor,
  output logic [N_CARDS-1:0]   face_up,
  output logic [N_CARDS-1:0]   matched,
  output logic [7:0]           moves,
  output logic                 busy,
  output logic                 won
);

  localparam int unsigned TIMER_W = $clog2(SHOW_CYCLES);

  logic up_e, down_e, left_e, right_e, sel_e;

  btn_edge u_up    (.clk(clk), .reset(reset), .btn_i(btn_up),    .pulse_o(up_e));
  btn_edge u_down  (.clk(clk), .reset(reset), .btn_i(btn_down),  .pulse_o(down_e));
  btn_edge u_left  (.clk(clk), .reset(reset), .btn_i(btn_left),  .pulse_o(left_e));
  btn_edge u_right (.clk(clk), .reset(reset), .btn_i(btn_right), .pulse_o(right_e));
  btn_edge u_sel   (.clk(clk), .reset(reset), .btn_i(btn_sel),   .pulse_o(sel_e));

  state_e               state_q;
  logic [TIMER_W-1:0]   timer_q;
  logic [IDX_W-1:0]     cursor_q, cursor_d;
  logic [N_CARDS-1:0]   face_up_q, matched_q;
  logic [7:0]           moves_q;
  logic                 won_q;
  logic [IDX_W-1:0]     first_q, second_q;

  logic [N_CARDS-1:0]   pair_mask;
  logic [N_CARDS-1:0]   matched_next;
  logic                 is_pair;
  logic [7:0]           moves_inc;

  // One direction per cycle, up > down > left > right, wrapping in row/column.
  always_comb begin
    cursor_d = cursor_q;
    if (state_q != WON) begin
      if (up_e)         cursor_d = {cursor_q[3:2] - 2'd1, cursor_q[1:0]};
      else if (down_e)  cursor_d = {cursor_q[3:2] + 2'd1, cursor_q[1:0]};
      else if (left_e)  cursor_d = {cursor_q[3:2], cursor_q[1:0] - 2'd1};
      else if (right_e) cursor_d = {cursor_q[3:2], cursor_q[1:0] + 2'd1};
    end
  end

  always_comb begin
    pair_mask    = (N_CARDS'(1) << first_q) | (N_CARDS'(1) << second_q);
    matched_next = matched_q | pair_mask;
    is_pair      = (pair_id(LAYOUT, first_q) == pair_id(LAYOUT, second_q));
    moves_inc    = (moves_q == 8'hFF) ? moves_q : moves_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= PICK1;
      timer_q   <= '0;
      cursor_q  <= '0;
      face_up_q <= '0;
      matched_q <= '0;
      moves_q   <= '0;
      won_q     <= 1'b0;
      first_q   <= '0;
      second_q  <= '0;
    end else begin
      cursor_q <= cursor_d;
      // Picks always use the pre-move cursor.
      unique case (state_q)
        PICK1: begin
          if (sel_e && !face_up_q[cursor_q]) begin
            face_up_q[cursor_q] <= 1'b1;
            first_q             <= cursor_q;
            state_q             <= PICK2;
          end
        end
        PICK2: begin
          if (sel_e && !face_up_q[cursor_q]) begin
            face_up_q[cursor_q] <= 1'b1;
            second_q            <= cursor_q;
            moves_q             <= moves_inc;
            timer_q             <= '0;
            state_q             <= SHOW;
          end
        end
        SHOW: begin
          if (timer_q == TIMER_W'(SHOW_CYCLES - 1)) state_q <= EVAL;
          else                                      timer_q <= timer_q + TIMER_W'(1);
        end
        EVAL: begin
          if (is_pair) begin
            matched_q <= matched_next;
            if (matched_next == '1) begin
              face_up_q <= '1;
              won_q     <= 1'b1;
              state_q   <= WON;
            end else begin
              state_q <= PICK1;
            end
          end else begin
            face_up_q <= face_up_q & ~pair_mask;
            state_q   <= PICK1;
          end
        end
        WON: ;
        default: state_q <= PICK1;
      endcase
    end
  end

  assign cursor  = cursor_q;
  assign face_up = face_up_q;
  assign matched = matched_q;
  assign moves   = moves_q;
  assign won     = won_q;
  assign busy    = (state_q == SHOW) || (state_q == EVAL);

endmodule

// File: tb/tb_memory_game_ctrl.sv
// Randomized self-checking bench for memory_game_ctrl against a card-level game model.
module tb_memory_game_ctrl;

  localparam int unsigned S = 8;
  localparam logic [47:0] LAY = 48'hFAC688_FAC688;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_sel = 1'b0;
  logic [3:0]  cursor;
  logic [15:0] face_up, matched;
  logic [7:0]  moves;
  logic        busy, won;

  int total = 0;
  int bad   = 0;

  memory_game_ctrl #(.SHOW_CYCLES(S)) dut (
    .clk(clk), .reset(reset),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_sel(btn_sel),
    .cursor(cursor), .face_up(face_up), .matched(matched), .moves(moves),
    .busy(busy), .won(won)
  );

  always #5 clk = ~clk;

  // Game model: phase 0 = awaiting first pick, 1 = second pick, 2 = cards on show.
  int          m_row, m_col, m_phase, m_first, m_second, m_moves;
  logic [15:0] m_fu, m_mt;
  bit          m_won;

  logic [45:0] dut_vec;
  assign dut_vec = {cursor, face_up, matched, moves, busy, won};

  function automatic logic [45:0] mdl_vec();
    return {4'(m_row * 4 + m_col), m_fu, m_mt, 8'(m_moves), (m_phase == 2), m_won};
  endfunction

  function automatic int card_id(int i);
    logic [47:0] l;
    l = LAY >> (3 * i);
    return int'(l[2:0]);
  endfunction

  task automatic mdl_reset();
    m_row = 0; m_col = 0; m_phase = 0; m_first = 0; m_second = 0; m_moves = 0;
    m_fu = '0; m_mt = '0; m_won = 0;
  endtask

  // m = {up, down, left, right, sel}
  task automatic mdl_press(input logic [4:0] m);
    int c;
    c = m_row * 4 + m_col;
    if (!m_won) begin
      if (m[0] && !m_fu[c]) begin
        if (m_phase == 0) begin
          m_fu[c] = 1'b1; m_first = c; m_phase = 1;
        end else if (m_phase == 1) begin
          m_fu[c] = 1'b1; m_second = c; m_phase = 2;
          m_moves = (m_moves < 255) ? m_moves + 1 : 255;
        end
      end
      if (m[4])      m_row = (m_row + 3) % 4;
      else if (m[3]) m_row = (m_row + 1) % 4;
      else if (m[2]) m_col = (m_col + 3) % 4;
      else if (m[1]) m_col = (m_col + 1) % 4;
    end
  endtask

  task automatic mdl_eval();
    if (card_id(m_first) == card_id(m_second)) begin
      m_mt[m_first] = 1'b1; m_mt[m_second] = 1'b1;
      if (m_mt == 16'hFFFF) begin m_won = 1; m_fu = 16'hFFFF; end
    end else begin
      m_fu[m_first] = 1'b0; m_fu[m_second] = 1'b0;
    end
    m_phase = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    {btn_up, btn_down, btn_left, btn_right, btn_sel} = '0;
    @(negedge clk);
    reset = 1'b0;
    mdl_reset();
  endtask

  // One-cycle press; returns at the negedge after the press has taken effect.
  task automatic press(input logic [4:0] m);
    @(negedge clk);
    {btn_up, btn_down, btn_left, btn_right, btn_sel} = m;
    @(negedge clk);
    {btn_up, btn_down, btn_left, btn_right, btn_sel} = '0;
    @(negedge clk);
    mdl_press(m);
  endtask

  task automatic goto(input int target);
    while (m_col != target % 4) press(5'b00010);
    while (m_row != target / 4) press(5'b01000);
  endtask

  // Runs out the show window (optionally with select noise) and applies the outcome.
  task automatic wait_eval(input bit noise);
    for (int k = 1; k <= int'(S) + 1; k++) begin
      @(negedge clk);
      btn_sel = (noise && k <= int'(S) - 3) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    mdl_eval();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (dut_vec !== 46'd0) begin
      bad++; $display("FAIL reset_initial: got %h want 0", dut_vec);
    end
    press(5'b00001); press(5'b00010); press(5'b00001);
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL reset_pre_busy: got %b want 1", busy);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({face_up, matched, moves, cursor, busy, won} !== 46'd0) begin
      bad++; $display("FAIL reset_mid_show: got %h/%h/%0d/%0d/%b/%b want all 0",
                      face_up, matched, moves, cursor, busy, won);
    end
    reset = 1'b0;
    mdl_reset();
    repeat (S + 2) @(negedge clk);
    total++;
    if (dut_vec !== mdl_vec()) begin
      bad++; $display("FAIL reset_no_pending_eval: got %h want %h", dut_vec, mdl_vec());
    end
  endtask

  task automatic test_cursor();
    do_reset();
    press(5'b00100);
    total++;
    if (cursor !== 4'd3) begin bad++; $display("FAIL cursor_left_wrap: got %0d want 3", cursor); end
    press(5'b10000);
    total++;
    if (cursor !== 4'd15) begin bad++; $display("FAIL cursor_up_wrap: got %0d want 15", cursor); end
    press(5'b10010);
    total++;
    if (cursor !== 4'd11) begin bad++; $display("FAIL cursor_priority: got %0d want 11", cursor); end
    for (int i = 0; i < 12; i++) begin
      press(5'($urandom_range(1, 15)) << 1);
      total++;
      if (cursor !== 4'(m_row * 4 + m_col)) begin
        bad++; $display("FAIL cursor_rand%0d: got %0d want %0d", i, cursor, m_row * 4 + m_col);
      end
    end
  endtask

  task automatic test_match();
    do_reset();
    @(negedge clk); btn_sel = 1'b1;
    @(negedge clk); btn_sel = 1'b0;
    total++;
    if (face_up !== 16'h0000) begin bad++; $display("FAIL pick_latency_early: got %h want 0000", face_up); end
    @(negedge clk);
    mdl_press(5'b00001);
    total++;
    if (face_up !== 16'h0001) begin bad++; $display("FAIL pick_latency: got %h want 0001", face_up); end
    goto(8);
    press(5'b00001);
    for (int k = 1; k <= int'(S); k++) begin
      @(negedge clk);
      total++;
      if ({busy, face_up, matched} !== {1'b1, 16'h0101, 16'h0000}) begin
        bad++; $display("FAIL show_hold%0d: got busy=%b fu=%h mt=%h want 1/0101/0000", k, busy, face_up, matched);
      end
    end
    @(negedge clk);
    mdl_eval();
    total++;
    if ({busy, face_up, matched, moves} !== {1'b0, 16'h0101, 16'h0101, 8'd1}) begin
      bad++; $display("FAIL match_result: got busy=%b fu=%h mt=%h mv=%0d want 0/0101/0101/1", busy, face_up, matched, moves);
    end
  endtask

  task automatic test_mismatch();
    do_reset();
    press(5'b00001); press(5'b00010); press(5'b00001);
    wait_eval(1'b1);
    total++;
    if ({face_up, matched, moves, busy} !== {16'h0, 16'h0, 8'd1, 1'b0}) begin
      bad++; $display("FAIL mismatch_flip: got fu=%h mt=%h mv=%0d busy=%b want 0/0/1/0", face_up, matched, moves, busy);
    end
    total++;
    if (dut_vec !== mdl_vec()) begin bad++; $display("FAIL mismatch_model: got %h want %h", dut_vec, mdl_vec()); end
  endtask

  task automatic test_ignored_picks();
    do_reset();
    press(5'b00001);
    press(5'b00001);
    total++;
    if ({face_up, busy, moves} !== {16'h0001, 1'b0, 8'd0}) begin
      bad++; $display("FAIL repick_same: got fu=%h busy=%b mv=%0d want 0001/0/0", face_up, busy, moves);
    end
    goto(8); press(5'b00001); wait_eval(1'b0);
    total++;
    if (matched !== 16'h0101) begin bad++; $display("FAIL repick_pair: got %h want 0101", matched); end
    goto(0); press(5'b00001);
    total++;
    if (dut_vec !== mdl_vec() || face_up !== 16'h0101) begin
      bad++; $display("FAIL pick_matched: got %h want %h", dut_vec, mdl_vec());
    end
    press(5'b00010); press(5'b00001);
    total++;
    if ({face_up, busy} !== {16'h0103, 1'b0}) begin
      bad++; $display("FAIL still_pick1: got fu=%h busy=%b want 0103/0", face_up, busy);
    end
  endtask

  task automatic test_random();
    logic [4:0] m;
    do_reset();
    for (int i = 0; i < 150; i++) begin
      m = 5'($urandom);
      if ($urandom_range(0, 2) == 0) m[0] = 1'b1;
      press(m);
      total++;
      if (dut_vec !== mdl_vec()) begin bad++; $display("FAIL rand_press%0d: got %h want %h", i, dut_vec, mdl_vec()); end
      if (m_phase == 2) begin
        wait_eval(1'b1);
        total++;
        if (dut_vec !== mdl_vec()) begin bad++; $display("FAIL rand_eval%0d: got %h want %h", i, dut_vec, mdl_vec()); end
      end
    end
  endtask

  task automatic test_win_and_saturate();
    logic [45:0] frozen;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      goto(i); press(5'b00001);
      goto(i + 8); press(5'b00001);
      wait_eval(1'b0);
    end
    total++;
    if ({won, face_up, matched, moves} !== {1'b1, 16'hFFFF, 16'hFFFF, 8'd8}) begin
      bad++; $display("FAIL win: got won=%b fu=%h mt=%h mv=%0d want 1/FFFF/FFFF/8", won, face_up, matched, moves);
    end
    frozen = dut_vec;
    for (int i = 0; i < 10; i++) press(5'($urandom_range(1, 31)));
    total++;
    if (dut_vec !== mdl_vec()) begin bad++; $display("FAIL won_frozen: got %h want %h (was %h)", dut_vec, mdl_vec(), frozen); end
    do_reset();
    for (int i = 0; i < 300; i++) begin
      press(5'b00011);
      press(5'b00101);
      wait_eval(1'b0);
      total++;
      if (dut_vec !== mdl_vec()) begin bad++; $display("FAIL sat_iter%0d: got %h want %h", i, dut_vec, mdl_vec()); end
    end
    total++;
    if (moves !== 8'd255) begin bad++; $display("FAIL moves_saturate: got %0d want 255", moves); end
  endtask

  initial begin
    mdl_reset();
    repeat (2) @(negedge clk);
    test_reset();
    test_cursor();
    test_match();
    test_mismatch();
    test_ignored_picks();
    test_random();
    test_win_and_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
